// File: rtl/eoc_status_if.sv
// Signal bundle between the end-of-computation monitor and whatever arms it and reads its verdict.
// The monitor takes the slave modport; the controlling side (SoC glue or bench) takes the master modport.
interface eoc_status_if #(
  parameter int NUM_CH    = 4,
  parameter int CODE_W    = 8,
  parameter int TIMEOUT_W = 32
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  // code_valid_i is a one-way write strobe with no ready: a write is taken on every clock edge
  // where it is high, and accepted or silently dropped by the monitor's own rules.
  logic                 start_i;
  logic [NUM_CH-1:0]    done_mask_i;
  logic [TIMEOUT_W-1:0] timeout_i;
  logic [NUM_CH-1:0]    done_i;
  logic                 code_valid_i;
  logic [CH_W-1:0]      code_ch_i;
  logic [CODE_W-1:0]    code_i;

  logic                 busy_o;
  logic                 finished_o;
  logic [1:0]           exit_status_o;
  logic [NUM_CH-1:0]    ch_done_o;
  logic [NUM_CH-1:0]    fail_mask_o;
  logic [TIMEOUT_W-1:0] cycles_o;
  logic                 irq_o;
  logic [1:0]           state_dbg_o;

  modport master (
    output start_i, done_mask_i, timeout_i, done_i, code_valid_i, code_ch_i, code_i,
    input  busy_o, finished_o, exit_status_o, ch_done_o, fail_mask_o, cycles_o, irq_o,
           state_dbg_o
  );

  modport slave (
    input  start_i, done_mask_i, timeout_i, done_i, code_valid_i, code_ch_i, code_i,
    output busy_o, finished_o, exit_status_o, ch_done_o, fail_mask_o, cycles_o, irq_o,
           state_dbg_o
  );
endinterface

// File: rtl/eoc_status_monitor.sv
// End-of-computation monitor: synchronises per-channel done lines, collects return codes,
// runs a cycle watchdog and reports one exit verdict with a single-cycle IRQ.
module eoc_status_monitor #(
  parameter int NUM_CH      = 4,
  parameter int CODE_W      = 8,
  parameter int TIMEOUT_W   = 32,
  parameter int SYNC_STAGES = 2
) (
  input logic         clk,
  input logic         rst,
  eoc_status_if.slave bus
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_DONE    = 2'd2,
    S_TIMEOUT = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [NUM_CH-1:0]    sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0]    prev_q;
  logic [NUM_CH-1:0]    rise;

  logic [NUM_CH-1:0]    mask_q, mask_d;
  logic [TIMEOUT_W-1:0] limit_q, limit_d;
  logic [NUM_CH-1:0]    ch_done_q, ch_done_d;
  logic [CODE_W-1:0]    code_q [NUM_CH];
  logic [CODE_W-1:0]    code_d [NUM_CH];
  logic [TIMEOUT_W-1:0] cycles_q, cycles_d;
  logic [1:0]           status_q, status_d;
  logic                 irq_q, irq_d;
  logic                 busy_q, finished_q;
  logic [NUM_CH-1:0]    run_fail;
  logic [NUM_CH-1:0]    fail_mask;

  // Synchroniser chain plus one edge register; a level that was already high is never an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= bus.done_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    limit_d   = limit_q;
    ch_done_d = ch_done_q;
    code_d    = code_q;
    cycles_d  = cycles_q;
    status_d  = status_q;
    irq_d     = 1'b0;
    run_fail  = '0;

    case (state_q)
      S_RUN: begin
        // Matching against each legal index means a code_ch_i >= NUM_CH never lands anywhere.
        for (int c = 0; c < NUM_CH; c++) begin
          if (bus.code_valid_i && bus.code_ch_i == CH_W'(c) && !ch_done_q[c])
            code_d[c] = bus.code_i;
          run_fail[c] = |code_d[c];
        end
        ch_done_d = ch_done_q | rise;
        if (cycles_q != '1) cycles_d = cycles_q + TIMEOUT_W'(1);

        if ((ch_done_d & mask_q) == mask_q) begin
          state_d  = S_DONE;
          irq_d    = 1'b1;
          status_d = (|(run_fail & mask_q)) ? 2'd2 : 2'd1;
        end else if (limit_q != '0 && cycles_q == limit_q - TIMEOUT_W'(1)) begin
          state_d  = S_TIMEOUT;
          irq_d    = 1'b1;
          status_d = 2'd3;
        end
      end
      default: begin
        if (bus.start_i) begin
          state_d   = S_RUN;
          mask_d    = bus.done_mask_i;
          limit_d   = bus.timeout_i;
          ch_done_d = '0;
          for (int c = 0; c < NUM_CH; c++) code_d[c] = '0;
          cycles_d  = '0;
          status_d  = 2'd0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q     <= '0;
      limit_q    <= '0;
      ch_done_q  <= '0;
      for (int c = 0; c < NUM_CH; c++) code_q[c] <= '0;
      cycles_q   <= '0;
      status_q   <= 2'd0;
      irq_q      <= 1'b0;
      busy_q     <= 1'b0;
      finished_q <= 1'b0;
    end else begin
      mask_q     <= mask_d;
      limit_q    <= limit_d;
      ch_done_q  <= ch_done_d;
      code_q     <= code_d;
      cycles_q   <= cycles_d;
      status_q   <= status_d;
      irq_q      <= irq_d;
      busy_q     <= (state_d == S_RUN);
      finished_q <= (state_d == S_DONE) || (state_d == S_TIMEOUT);
    end
  end

  always_comb begin
    fail_mask = '0;
    for (int c = 0; c < NUM_CH; c++) fail_mask[c] = |code_q[c];
  end

  assign bus.busy_o        = busy_q;
  assign bus.finished_o    = finished_q;
  assign bus.exit_status_o = status_q;
  assign bus.ch_done_o     = ch_done_q;
  assign bus.fail_mask_o   = fail_mask;
  assign bus.cycles_o      = cycles_q;
  assign bus.irq_o         = irq_q;
  assign bus.state_dbg_o   = state_q;
endmodule

// File: tb/tb_eoc_status_monitor.sv
// Bench for eoc_status_monitor: directed scenarios with literal expectations plus random traffic,
// all outputs compared every cycle against a behavioural model of the monitor.
module tb_eoc_status_monitor;
  localparam int NCH = 4;
  localparam int CW  = 8;
  localparam int TW  = 12;
  localparam int S   = 2;
  localparam longint SAT = (64'd1 << TW) - 1;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   irq_cnt = 0;

  eoc_status_if #(.NUM_CH(NCH), .CODE_W(CW), .TIMEOUT_W(TW)) bus ();

  eoc_status_monitor #(.NUM_CH(NCH), .CODE_W(CW), .TIMEOUT_W(TW), .SYNC_STAGES(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- checking helper ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [NCH-1:0] hist [S+1];
  int             m_phase;      // 0 idle, 1 running, 2 finished
  logic [1:0]     m_status;
  logic           m_irq;
  longint         m_cycles;
  longint         m_limit;
  logic [NCH-1:0] m_mask;
  logic [NCH-1:0] m_ch_done;
  int             m_code [NCH];
  logic           model_ok = 1'b0;
  logic [1:0]     exp_q [$];
  logic [NCH-1:0] m_rise;
  longint         m_old;
  logic           m_anyfail;

  always @(posedge clk) begin
    m_rise = hist[S-1] & ~hist[S];
    if (rst) begin
      m_phase = 0; m_status = 2'd0; m_irq = 1'b0; m_cycles = 0; m_limit = 0;
      m_mask = '0; m_ch_done = '0;
      for (int c = 0; c < NCH; c++) m_code[c] = 0;
      for (int i = 0; i <= S; i++) hist[i] = '0;
    end else begin
      for (int i = S; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = bus.done_i;
      m_irq = 1'b0;
      if (m_phase != 1) begin
        if (bus.start_i) begin
          m_phase = 1; m_status = 2'd0; m_cycles = 0;
          m_mask = bus.done_mask_i; m_limit = longint'(bus.timeout_i);
          m_ch_done = '0;
          for (int c = 0; c < NCH; c++) m_code[c] = 0;
        end
      end else begin
        if (bus.code_valid_i && int'(bus.code_ch_i) < NCH && !m_ch_done[bus.code_ch_i])
          m_code[bus.code_ch_i] = int'(bus.code_i);
        m_ch_done = m_ch_done | m_rise;
        m_old = m_cycles;
        m_cycles = (m_cycles == SAT) ? SAT : m_cycles + 1;
        m_anyfail = 1'b0;
        for (int c = 0; c < NCH; c++) if (m_mask[c] && m_code[c] != 0) m_anyfail = 1'b1;
        if ((m_ch_done & m_mask) == m_mask) begin
          m_phase = 2; m_irq = 1'b1; m_status = m_anyfail ? 2'd2 : 2'd1;
          exp_q.push_back(m_status);
        end else if (m_limit != 0 && m_old == m_limit - 1) begin
          m_phase = 2; m_irq = 1'b1; m_status = 2'd3;
          exp_q.push_back(m_status);
        end
      end
    end
    model_ok = 1'b1;
  end

  // ---------------- per-cycle compare + verdict scoreboard ----------------
  logic [NCH-1:0] exp_fail;
  logic [1:0]     exp_verdict;

  always @(negedge clk) begin
    if (model_ok) begin
      for (int c = 0; c < NCH; c++) exp_fail[c] = (m_code[c] != 0);
      check("busy",        bus.busy_o,        m_phase == 1);
      check("finished",    bus.finished_o,    m_phase == 2);
      check("exit_status", bus.exit_status_o, m_status);
      check("ch_done",     bus.ch_done_o,     m_ch_done);
      check("fail_mask",   bus.fail_mask_o,   exp_fail);
      check("cycles",      bus.cycles_o,      m_cycles);
      check("irq",         bus.irq_o,         m_irq);
      if (bus.irq_o === 1'b1) begin
        irq_cnt++;
        exp_verdict = (exp_q.size() > 0) ? exp_q.pop_front() : 2'd0;
        check("irq_verdict", bus.exit_status_o, exp_verdict);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input logic [NCH-1:0] mask, input int limit);
    bus.done_mask_i = mask;
    bus.timeout_i   = TW'(limit);
    bus.start_i     = 1'b1;
    @(negedge clk);
    bus.start_i     = 1'b0;
  endtask

  task automatic write_code(input int ch, input int code);
    bus.code_valid_i = 1'b1;
    bus.code_ch_i    = 2'(ch);
    bus.code_i       = CW'(code);
    @(negedge clk);
    bus.code_valid_i = 1'b0;
  endtask

  task automatic wait_finished(input string name, input int budget);
    int n;
    n = 0;
    while (bus.finished_o !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, bus.finished_o, 1'b1);
  endtask

  task automatic idle_done_low();
    bus.done_i = '0;
    repeat (4) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  int irq0;
  int lat;

  initial begin
    rst = 1'b1;
    bus.start_i = 1'b0; bus.done_mask_i = '0; bus.timeout_i = '0; bus.done_i = '0;
    bus.code_valid_i = 1'b0; bus.code_ch_i = '0; bus.code_i = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_busy", bus.busy_o, 0);
    check("reset_status", bus.exit_status_o, 0);
    check("reset_cycles", bus.cycles_o, 0);

    // T1: two masked channels pass
    irq0 = irq_cnt;
    pulse_start(4'b0101, 1000);
    write_code(0, 0);
    write_code(2, 0);
    bus.done_i = 4'b0101;
    wait_finished("t1_finish", 20);
    repeat (2) @(negedge clk);
    check("t1_status", bus.exit_status_o, 1);
    check("t1_ch_done", bus.ch_done_o, 4'b0101);
    check("t1_irq_count", irq_cnt - irq0, 1);
    idle_done_low();

    // T2: re-arm from DONE, one masked channel fails
    pulse_start(4'b0101, 1000);
    write_code(0, 0);
    write_code(2, 8'h2A);
    bus.done_i = 4'b0101;
    wait_finished("t2_finish", 20);
    check("t2_status", bus.exit_status_o, 2);
    check("t2_fail_mask", bus.fail_mask_o, 4'b0100);
    idle_done_low();

    // T3: watchdog
    irq0 = irq_cnt;
    pulse_start(4'b0001, 50);
    wait_finished("t3_finish", 80);
    repeat (2) @(negedge clk);
    check("t3_status", bus.exit_status_o, 3);
    check("t3_cycles", bus.cycles_o, 50);
    check("t3_irq_count", irq_cnt - irq0, 1);

    // T4: completion lands on the watchdog cycle -> done wins
    pulse_start(4'b0001, 40);
    repeat (40 - 3) @(negedge clk);
    bus.done_i = 4'b0001;
    wait_finished("t4_finish", 20);
    check("t4_status", bus.exit_status_o, 1);
    check("t4_cycles", bus.cycles_o, 40);
    idle_done_low();

    // T4b: completion one cycle late -> timeout, ch_done frozen afterwards
    pulse_start(4'b0001, 40);
    repeat (40 - 2) @(negedge clk);
    bus.done_i = 4'b0001;
    wait_finished("t4b_finish", 20);
    repeat (4) @(negedge clk);
    check("t4b_status", bus.exit_status_o, 3);
    check("t4b_ch_done", bus.ch_done_o, 0);
    idle_done_low();

    // T5: level high at start is not an edge; latency of a fresh edge
    bus.done_i = 4'b0001;
    repeat (5) @(negedge clk);
    pulse_start(4'b0001, 0);
    repeat (10) @(negedge clk);
    check("t5_still_busy", bus.busy_o, 1);
    bus.done_i = 4'b0000;
    repeat (3) @(negedge clk);
    bus.done_i = 4'b0001;
    lat = 0;
    while (bus.finished_o !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("t5_latency", lat, S + 1);
    check("t5_status", bus.exit_status_o, 1);
    idle_done_low();

    // T6: overwrite before done, write after done ignored, reset mid-run, zero mask
    pulse_start(4'b1111, 0);
    write_code(3, 7);
    write_code(3, 0);
    bus.done_i = 4'b0001;
    repeat (5) @(negedge clk);
    write_code(0, 9);
    check("t6_fail_after_done", bus.fail_mask_o, 0);
    bus.done_i = 4'b0000;
    irq0 = irq_cnt;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_rst_busy", bus.busy_o, 0);
    check("t6_rst_ch_done", bus.ch_done_o, 0);
    check("t6_rst_cycles", bus.cycles_o, 0);
    check("t6_rst_irq", irq_cnt - irq0, 0);
    pulse_start(4'b0000, 0);
    check("t6_zero_mask_busy", bus.busy_o, 1);
    @(negedge clk);
    check("t6_zero_mask_finished", bus.finished_o, 1);
    check("t6_zero_mask_status", bus.exit_status_o, 1);
    write_code(1, 5);
    check("t6_write_outside_run", bus.fail_mask_o, 0);

    // cycle counter saturation with the watchdog disabled
    pulse_start(4'b0001, 0);
    repeat (4100) @(negedge clk);
    check("sat_cycles", bus.cycles_o, SAT);
    bus.done_i = 4'b0001;
    wait_finished("sat_finish", 20);
    idle_done_low();

    // random traffic, checked only by the per-cycle model compare
    for (int cyc = 0; cyc < 4000; cyc++) begin
      bus.start_i = ($urandom_range(0, 24) == 0);
      if (bus.start_i) begin
        bus.done_mask_i = NCH'($urandom_range(0, 15));
        bus.timeout_i   = ($urandom_range(0, 3) == 0) ? '0 : TW'($urandom_range(1, 120));
      end
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(0, 11) == 0) bus.done_i[c] = ~bus.done_i[c];
      bus.code_valid_i = ($urandom_range(0, 3) == 0);
      bus.code_ch_i    = 2'($urandom_range(0, NCH - 1));
      bus.code_i       = ($urandom_range(0, 2) == 0) ? CW'($urandom_range(1, 255)) : '0;
      rst = ($urandom_range(0, 399) == 0);
      @(negedge clk);
    end
    rst = 1'b0; bus.start_i = 1'b0; bus.code_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    check("verdict_queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
